handshake_rr_arbiter: RTL

//   Shares one downstream ready/valid channel (the RTL_unq1 handshake port) between N_REQ

---
 rtl/handshake_rr_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging N_REQ ready/valid requesters onto one registered downstream channel.
// The winner index travels with each beat on out_id.
module handshake_rr_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned WIDTH = 5,
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id
);

    localparam int unsigned LAST = N_REQ - 1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic [ID_W-1:0]  ptr_eff;
    logic [ID_W-1:0]  win;
    logic             found;
    logic             can_load;
    logic             accept;
    int               idx;

    // Search ptr, ptr+1, ... with wrap; out-of-range pointer codes start from 0.
    always_comb begin
        ptr_eff = (int'(ptr_q) < int'(N_REQ)) ? ptr_q : '0;
        found   = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = int'(ptr_eff) + k;
            if (idx >= int'(N_REQ)) begin
                idx = idx - int'(N_REQ);
            end
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        can_load  = ~out_valid_q | out_ready;
        req_ready = '0;
        if (can_load && found && !RESET) begin
            req_ready[win] = 1'b1;
        end
        accept = |(req_valid & req_ready);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[int'(win)*WIDTH +: WIDTH];
            out_id_d    = win;
            ptr_d       = (win == ID_W'(LAST)) ? '0 : win + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule
